// File: rtl/key_debounce_bank.sv
// N-channel key front end: 2-flop synchroniser, per-key debounce, press/release pulses and
// optional auto-repeat pulses while a key is held.
module key_debounce_bank #(
  parameter int unsigned N_KEYS       = 2,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter bit          ACTIVE_LOW   = 1'b0,
  parameter bit          REPEAT_EN    = 1'b0,
  parameter int unsigned REPEAT_DLY   = 1000,
  parameter int unsigned REPEAT_PER   = 250
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [N_KEYS-1:0] in_key,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_repeat,
  output logic              o_any_press
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rp_state_e;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic           sync1_q, sync2_q;
    logic           level_d, level_q;
    logic           press_d, press_q;
    logic           release_d, release_q;
    logic [DbW-1:0] db_cnt_d, db_cnt_q;

    // Any return of the synced pin to the accepted level restarts the count.
    always_comb begin
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      if (sync2_q == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) begin
        level_d  = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        db_cnt_q  <= '0;
      end else begin
        sync1_q   <= in_key[k] ^ ACTIVE_LOW;
        sync2_q   <= sync1_q;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        db_cnt_q  <= db_cnt_d;
      end
    end

    assign o_level[k]   = level_q;
    assign o_press[k]   = press_q;
    assign o_release[k] = release_q;

    if (REPEAT_EN) begin : g_rep
      localparam int unsigned RpMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
      localparam int unsigned RpW   = $clog2(RpMax + 1);

      rp_state_e      state_d, state_q;
      logic [RpW-1:0] rp_cnt_d, rp_cnt_q;
      logic           repeat_d, repeat_q;

      // Uses the next debounced level so no repeat can coincide with the release pulse.
      always_comb begin
        state_d  = state_q;
        rp_cnt_d = rp_cnt_q;
        repeat_d = 1'b0;
        if (!level_d) begin
          state_d  = StIdle;
          rp_cnt_d = '0;
        end else begin
          unique case (state_q)
            StIdle: begin
              if (press_d) begin
                state_d  = StDelay;
                rp_cnt_d = '0;
              end
            end
            StDelay: begin
              if (rp_cnt_q == RpW'(REPEAT_DLY - 1)) begin
                repeat_d = 1'b1;
                state_d  = StRepeat;
                rp_cnt_d = '0;
              end else begin
                rp_cnt_d = rp_cnt_q + 1'b1;
              end
            end
            StRepeat: begin
              if (rp_cnt_q == RpW'(REPEAT_PER - 1)) begin
                repeat_d = 1'b1;
                rp_cnt_d = '0;
              end else begin
                rp_cnt_d = rp_cnt_q + 1'b1;
              end
            end
            default: begin
              state_d  = StIdle;
              rp_cnt_d = '0;
            end
          endcase
        end
      end

      always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
          state_q  <= StIdle;
          rp_cnt_q <= '0;
          repeat_q <= 1'b0;
        end else begin
          state_q  <= state_d;
          rp_cnt_q <= rp_cnt_d;
          repeat_q <= repeat_d;
        end
      end

      assign o_repeat[k] = repeat_q;
    end else begin : g_no_rep
      assign o_repeat[k] = 1'b0;
    end
  end

  assign o_any_press = |o_press;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Directed bench for key_debounce_bank: an active-high and an active-low instance run in
// lockstep; per-cycle expected output vectors are queued as stimulus advances and checked.
module tb_key_debounce_bank;

  localparam int DB  = 16;
  localparam int DLY = 20;
  localparam int PER = 5;
  localparam int NC  = 1024;

  logic       clk;
  logic       rst_n;
  logic [1:0] key_a, key_b;
  logic [1:0] lvl_a, prs_a, rel_a, rep_a, lvl_b, prs_b, rel_b, rep_b;
  logic       any_a, any_b;

  key_debounce_bank #(
    .N_KEYS(2), .DEBOUNCE_CYC(DB), .ACTIVE_LOW(1'b0), .REPEAT_EN(1'b1),
    .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut_a (
    .in_clk(clk), .in_rst(rst_n), .in_key(key_a), .o_level(lvl_a), .o_press(prs_a),
    .o_release(rel_a), .o_repeat(rep_a), .o_any_press(any_a)
  );

  key_debounce_bank #(
    .N_KEYS(2), .DEBOUNCE_CYC(DB), .ACTIVE_LOW(1'b1), .REPEAT_EN(1'b1),
    .REPEAT_DLY(DLY), .REPEAT_PER(PER)
  ) dut_b (
    .in_clk(clk), .in_rst(rst_n), .in_key(key_b), .o_level(lvl_b), .o_press(prs_b),
    .o_release(rel_b), .o_repeat(rep_b), .o_any_press(any_b)
  );

  typedef struct {
    int         cyc;
    logic [8:0] ea;
    logic [8:0] eb;
    string      tag;
  } item_t;

  item_t      sb[$];
  logic [8:0] exp_a [NC];
  logic [8:0] exp_b [NC];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  string      cur_tag = "reset";

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Vector layout: {any, repeat[1:0], release[1:0], press[1:0], level[1:0]}
  always @(negedge clk) begin
    logic [8:0] got_a, got_b;
    item_t      it;
    got_a = {any_a, rep_a, rel_a, prs_a, lvl_a};
    got_b = {any_b, rep_b, rel_b, prs_b, lvl_b};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      n_tests++;
      assert (got_a === it.ea && it.cyc == cyc) else begin
        n_fail++;
        $error("FAIL %s dut_a cyc=%0d got=%b exp=%b (item cyc %0d)", it.tag, cyc, got_a,
               it.ea, it.cyc);
      end
      n_tests++;
      assert (got_b === it.eb && it.cyc == cyc) else begin
        n_fail++;
        $error("FAIL %s dut_b cyc=%0d got=%b exp=%b (item cyc %0d)", it.tag, cyc, got_b,
               it.eb, it.cyc);
      end
    end
  end

  task automatic set_bit(input bit sel, input int t, input int b);
    if (t < NC) begin
      if (sel) exp_b[t][b] = 1'b1;
      else     exp_a[t][b] = 1'b1;
    end
  endtask

  // Clean pin hold from cycle s to e: level/press/release/repeats as seen at the outputs.
  task automatic exp_hold(input bit sel, input int ch, input int s, input int e,
                          input bit rel_pulse);
    int p = s + DB + 2;
    int q = e + DB + 2;
    for (int t = p; t < q; t++) set_bit(sel, t, ch);
    set_bit(sel, p, 2 + ch);
    if (rel_pulse) set_bit(sel, q, 4 + ch);
    for (int t = p + DLY; t < q; t += PER) set_bit(sel, t, 6 + ch);
  endtask

  task automatic run_to(input int t);
    item_t it;
    while (cyc < t) begin
      it.cyc = cyc + 1;
      it.ea  = exp_a[cyc+1];
      it.eb  = exp_b[cyc+1];
      it.ea[8] = |it.ea[3:2];
      it.eb[8] = |it.eb[3:2];
      it.tag = cur_tag;
      sb.push_back(it);
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      exp_a[i] = '0;
      exp_b[i] = '0;
    end
    rst_n = 1'b0;
    key_a = 2'b11;
    key_b = 2'b11;

    // Held keys through reset count as a fresh press once reset lifts.
    exp_hold(1'b0, 0, 4, 50, 1'b1);
    exp_hold(1'b0, 1, 4, 50, 1'b1);
    run_to(4);
    cur_tag = "reset_exit_press";
    rst_n = 1'b1;
    run_to(50);
    key_a = 2'b00;
    run_to(100);

    cur_tag = "bounce";
    for (int i = 0; i < 12; i++) begin
      run_to(100 + 5 * i);
      key_a[0] = (i % 2 == 0);
    end
    run_to(200);

    cur_tag = "clean_press";
    exp_hold(1'b0, 0, 200, 300, 1'b1);
    key_a[0] = 1'b1;
    run_to(300);
    key_a[0] = 1'b0;
    run_to(350);

    cur_tag = "repeat_key1";
    exp_hold(1'b0, 1, 350, 412, 1'b1);
    key_a[1] = 1'b1;
    run_to(412);
    key_a[1] = 1'b0;
    run_to(480);

    cur_tag = "simultaneous";
    exp_hold(1'b0, 0, 480, 500, 1'b1);
    exp_hold(1'b0, 1, 480, 500, 1'b1);
    key_a = 2'b11;
    run_to(500);
    key_a = 2'b00;
    run_to(600);

    cur_tag = "glitch_15";
    key_a[1] = 1'b1;
    run_to(615);
    key_a[1] = 1'b0;
    run_to(650);

    cur_tag = "glitch_16";
    exp_hold(1'b0, 1, 650, 666, 1'b1);
    key_a[1] = 1'b1;
    run_to(666);
    key_a[1] = 1'b0;
    run_to(720);

    cur_tag = "active_low_press";
    exp_hold(1'b1, 0, 720, 731, 1'b0);
    key_b[0] = 1'b0;
    run_to(748);
    cur_tag = "reset_mid_delay";
    rst_n = 1'b0;
    run_to(758);
    cur_tag = "active_low_repress";
    exp_hold(1'b1, 0, 758, 800, 1'b1);
    rst_n = 1'b1;
    run_to(800);
    key_b[0] = 1'b1;
    run_to(860);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
